// File: rtl/packet_pkg.sv
// Shared defaults for the packet datapath blocks.
package packet_pkg;

  localparam int PKT_DATA_WIDTH = 32;
  localparam int PKT_DEPTH      = 16;
  localparam int PKT_HDR_WIDTH  = 8;

endpackage

// File: rtl/fifo_mem.sv
// Packet FIFO storage: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is intentionally not reset; empty/full masking hides stale words.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pkt_fifo.sv
// Packet-aware synchronous FIFO with eop tagging, packet counting, header
// peek, sticky overflow/underflow flags and optional first-word-fall-through.
module pkt_fifo
  import packet_pkg::*;
#(
  parameter int DATA_WIDTH = PKT_DATA_WIDTH,
  parameter int DEPTH      = PKT_DEPTH,
  parameter int HDR_WIDTH  = PKT_HDR_WIDTH,
  parameter int AFULL_TH   = DEPTH - 2,
  parameter int AEMPTY_TH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     wr_eop,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     rd_eop,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   pkt_count,
  output logic [HDR_WIDTH-1:0]     header_out,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [DATA_WIDTH:0] head_word;
  logic [DATA_WIDTH-1:0] head_data;
  logic                head_eop;
  logic                wr_acc, rd_acc;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  assign wr_acc = wr_en && !full && !rst;
  assign rd_acc = rd_en && !empty && !rst;

  fifo_mem #(
    .WIDTH(DATA_WIDTH + 1),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr),
    .wdata({wr_eop, data_in}),
    .raddr(rd_ptr),
    .rdata(head_word)
  );

  assign head_data  = head_word[DATA_WIDTH-1:0];
  assign head_eop   = head_word[DATA_WIDTH];
  assign header_out = empty ? '0 : head_data[HDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_count <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({wr_acc && wr_eop, rd_acc && head_eop})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  // Sticky error flags: a new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow <= 1'b1;
      else if (clr_err)   overflow <= 1'b0;
      if (rd_en && empty) underflow <= 1'b1;
      else if (clr_err)   underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : head_data;
      assign rd_eop   = !empty && head_eop;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] data_q;
      logic                  eop_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          data_q <= '0;
          eop_q  <= 1'b0;
        end else if (rd_acc) begin
          data_q <= head_data;
          eop_q  <= head_eop;
        end
      end

      assign data_out = data_q;
      assign rd_eop   = eop_q;
    end
  endgenerate

endmodule
